// File: rtl/term_pkg.sv
// ============================================================================
//  Module      : term_pkg
//  Description : Shared geometry, control codes, state encoding and helpers
//                for the character-buffer writer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package term_pkg;

    localparam int COLS      = 80;
    localparam int ROWS      = 25;
    localparam int BUF_SIZE  = COLS * ROWS;
    localparam int ADDR_BITS = 11;
    localparam int ROW_BITS  = 5;
    localparam int COL_BITS  = 7;

    localparam logic [7:0] BLANK  = 8'h20;

    localparam logic [7:0] CC_BS  = 8'h08;
    localparam logic [7:0] CC_TAB = 8'h09;
    localparam logic [7:0] CC_LF  = 8'h0A;
    localparam logic [7:0] CC_FF  = 8'h0C;
    localparam logic [7:0] CC_CR  = 8'h0D;
    localparam logic [7:0] CC_DEL = 8'h7F;

    localparam logic [ADDR_BITS-1:0] c_addr_one  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] c_cols_a    = ADDR_BITS'(COLS);
    localparam logic [ADDR_BITS-1:0] c_buf_a     = ADDR_BITS'(BUF_SIZE);
    localparam logic [ADDR_BITS-1:0] c_last_line = ADDR_BITS'(BUF_SIZE - COLS);
    localparam logic [COL_BITS-1:0]  c_col_one   = COL_BITS'(1);
    localparam logic [COL_BITS-1:0]  c_cols_c    = COL_BITS'(COLS);
    localparam logic [COL_BITS-1:0]  c_last_col  = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0]  c_row_one   = ROW_BITS'(1);
    localparam logic [ROW_BITS-1:0]  c_last_row  = ROW_BITS'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_INIT       = 2'd0,
        ST_IDLE       = 2'd1,
        ST_CLEAR_LINE = 2'd2,
        ST_CLEAR_ALL  = 2'd3
    } state_t;

    // Start address of the following physical line, wrapping at the buffer end.
    function automatic logic [ADDR_BITS-1:0] next_line_base(input logic [ADDR_BITS-1:0] base);
        return (base == c_last_line) ? '0 : base + c_cols_a;
    endfunction

endpackage

`default_nettype wire

// File: rtl/term_writer_blank_filler.sv
// ============================================================================
//  Module      : blank_filler
//  Description : Sequential address generator for buffer clears; emits one
//                address per cycle from a base for a given length, then a
//                one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module blank_filler
    import term_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [ADDR_BITS-1:0] i_base,
    input  logic [ADDR_BITS-1:0] i_len,
    output logic                 o_busy,
    output logic [ADDR_BITS-1:0] o_addr,
    output logic                 o_done
);

    logic                 r_busy;
    logic [ADDR_BITS-1:0] r_addr;
    logic [ADDR_BITS-1:0] r_left;
    logic                 r_done;

    // Reset preloads a full-buffer sweep so the power-on clear needs no start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b1;
            r_addr <= '0;
            r_left <= c_buf_a;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_addr <= i_base;
            r_left <= i_len;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_addr <= r_addr + c_addr_one;
            r_left <= r_left - c_addr_one;
            r_done <= 1'b0;
            if (r_left == c_addr_one) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_busy = r_busy;
    assign o_addr = r_addr;
    assign o_done = r_done;

endmodule

`default_nettype wire

// File: rtl/term_writer.sv
// ============================================================================
//  Module      : term_writer
//  Description : Byte-stream terminal writer for the 80x25 character buffer:
//                control codes, cursor tracking, auto-wrap, offset scrolling.
//                Optional macro TERM_WRITER_TAB_EN enables 8-column tab stops.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module term_writer
    import term_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic [7:0]           buf_din,
    output logic [ADDR_BITS-1:0] buf_waddr,
    output logic                 buf_wen,
    output logic [ROW_BITS-1:0]  top_row,
    output logic [COL_BITS-1:0]  cur_col,
    output logic [ROW_BITS-1:0]  cur_row
);

    state_t               r_state,     w_state;
    logic                 r_in_ready,  w_in_ready;
    logic [7:0]           r_buf_din,   w_buf_din;
    logic [ADDR_BITS-1:0] r_buf_waddr, w_buf_waddr;
    logic                 r_buf_wen,   w_buf_wen;
    logic [ROW_BITS-1:0]  r_top_row,   w_top_row;
    logic [COL_BITS-1:0]  r_cur_col,   w_cur_col;
    logic [ROW_BITS-1:0]  r_cur_row,   w_cur_row;
    logic [ADDR_BITS-1:0] r_line_base, w_line_base;

    logic                 w_accept;
    logic                 w_newline;
    logic                 w_fill_start;
    logic [ADDR_BITS-1:0] w_fill_base;
    logic [ADDR_BITS-1:0] w_fill_len;
    logic                 w_fill_busy;
    logic [ADDR_BITS-1:0] w_fill_addr;
    logic                 w_fill_done;
    logic [ADDR_BITS-1:0] w_char_addr;

    assign w_accept    = in_valid && r_in_ready;
    assign w_char_addr = r_line_base + {{(ADDR_BITS-COL_BITS){1'b0}}, r_cur_col};

`ifdef TERM_WRITER_TAB_EN
    logic [COL_BITS-1:0]  w_tab_stop;
    assign w_tab_stop = {r_cur_col[COL_BITS-1:3] + 4'd1, 3'b000};
`endif

    blank_filler u_filler (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_fill_start),
        .i_base  (w_fill_base),
        .i_len   (w_fill_len),
        .o_busy  (w_fill_busy),
        .o_addr  (w_fill_addr),
        .o_done  (w_fill_done)
    );

    always_comb begin
        w_state      = r_state;
        w_buf_wen    = 1'b0;
        w_buf_waddr  = r_buf_waddr;
        w_buf_din    = r_buf_din;
        w_top_row    = r_top_row;
        w_cur_col    = r_cur_col;
        w_cur_row    = r_cur_row;
        w_line_base  = r_line_base;
        w_fill_start = 1'b0;
        w_fill_base  = r_line_base;
        w_fill_len   = c_cols_a;
        w_newline    = 1'b0;

        case (r_state)
            ST_INIT, ST_CLEAR_ALL, ST_CLEAR_LINE: begin
                if (w_fill_busy) begin
                    w_buf_wen   = 1'b1;
                    w_buf_waddr = w_fill_addr;
                    w_buf_din   = BLANK;
                end
                if (w_fill_done) begin
                    w_state = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (w_accept) begin
                    if (in_data == CC_LF) begin
                        w_cur_col = '0;
                        w_newline = 1'b1;
                    end else if (in_data == CC_CR) begin
                        w_cur_col = '0;
                    end else if (in_data == CC_BS) begin
                        if (r_cur_col != '0) begin
                            w_cur_col = r_cur_col - c_col_one;
                        end
                    end else if (in_data == CC_FF) begin
                        w_top_row    = '0;
                        w_cur_col    = '0;
                        w_cur_row    = '0;
                        w_line_base  = '0;
                        w_state      = ST_CLEAR_ALL;
                        w_fill_start = 1'b1;
                        w_fill_base  = '0;
                        w_fill_len   = c_buf_a;
`ifdef TERM_WRITER_TAB_EN
                    end else if (in_data == CC_TAB) begin
                        if (w_tab_stop >= c_cols_c) begin
                            w_cur_col = '0;
                            w_newline = 1'b1;
                        end else begin
                            w_cur_col = w_tab_stop;
                        end
`endif
                    end else if ((in_data >= BLANK) && (in_data != CC_DEL)) begin
                        w_buf_wen   = 1'b1;
                        w_buf_waddr = w_char_addr;
                        w_buf_din   = in_data;
                        if (r_cur_col == c_last_col) begin
                            w_cur_col = '0;
                            w_newline = 1'b1;
                        end else begin
                            w_cur_col = r_cur_col + c_col_one;
                        end
                    end
                end
            end

            default: begin
                w_state = ST_INIT;
            end
        endcase

        // On the last row the old top line becomes the new bottom line and is blanked.
        if (w_newline) begin
            w_line_base = next_line_base(r_line_base);
            if (r_cur_row != c_last_row) begin
                w_cur_row = r_cur_row + c_row_one;
            end else begin
                w_top_row    = (r_top_row == c_last_row) ? '0 : r_top_row + c_row_one;
                w_state      = ST_CLEAR_LINE;
                w_fill_start = 1'b1;
                w_fill_base  = next_line_base(r_line_base);
                w_fill_len   = c_cols_a;
            end
        end

        w_in_ready = (w_state == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_in_ready  <= 1'b0;
            r_buf_din   <= '0;
            r_buf_waddr <= '0;
            r_buf_wen   <= 1'b0;
            r_top_row   <= '0;
            r_cur_col   <= '0;
            r_cur_row   <= '0;
            r_line_base <= '0;
        end else begin
            r_state     <= w_state;
            r_in_ready  <= w_in_ready;
            r_buf_din   <= w_buf_din;
            r_buf_waddr <= w_buf_waddr;
            r_buf_wen   <= w_buf_wen;
            r_top_row   <= w_top_row;
            r_cur_col   <= w_cur_col;
            r_cur_row   <= w_cur_row;
            r_line_base <= w_line_base;
        end
    end

    assign in_ready  = r_in_ready;
    assign buf_din   = r_buf_din;
    assign buf_waddr = r_buf_waddr;
    assign buf_wen   = r_buf_wen;
    assign top_row   = r_top_row;
    assign cur_col   = r_cur_col;
    assign cur_row   = r_cur_row;

endmodule

`default_nettype wire

// File: tb/tb_term_writer.sv
// ============================================================================
//  Module      : tb_term_writer
//  Description : Scoreboard bench for term_writer with a screen-level model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_term_writer;

    localparam int COLS = 80;
    localparam int ROWS = 25;
    localparam int BUFN = COLS * ROWS;
`ifdef TERM_WRITER_TAB_EN
    localparam bit TAB_EN = 1'b1;
`else
    localparam bit TAB_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  buf_din;
    logic [10:0] buf_waddr;
    logic        buf_wen;
    logic [4:0]  top_row;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;

    term_writer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .buf_din   (buf_din),
        .buf_waddr (buf_waddr),
        .buf_wen   (buf_wen),
        .top_row   (top_row),
        .cur_col   (cur_col),
        .cur_row   (cur_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  col;
        logic [4:0]  row;
        logic [4:0]  top;
        logic        wen;
        logic [11:0] low;
    } cur_t;

    logic [18:0] q_wr[$];
    cur_t        q_cur[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit drv_done = 1'b0;
    bit mon_done = 1'b0;

    // Screen model: cursor and scroll offset, addresses from plain arithmetic.
    int m_top = 0;
    int m_col = 0;
    int m_row = 0;

    function automatic int phys(input int row);
        return ((m_top + row) % ROWS) * COLS;
    endfunction

    task automatic push_wr(input int addr, input logic [7:0] data);
        q_wr.push_back({11'(addr), data});
    endtask

    task automatic model_newline(output int low);
        low = 0;
        if (m_row < ROWS - 1) begin
            m_row = m_row + 1;
        end else begin
            m_top = (m_top + 1) % ROWS;
            for (int c = 0; c < COLS; c++) push_wr(phys(ROWS - 1) + c, 8'h20);
            low = COLS + 1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int   low;
        logic wen;
        cur_t e;
        low = 0;
        wen = 1'b0;
        if (b == 8'h0A) begin
            m_col = 0;
            model_newline(low);
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col = m_col - 1;
        end else if (b == 8'h0C) begin
            m_top = 0; m_col = 0; m_row = 0;
            for (int a = 0; a < BUFN; a++) push_wr(a, 8'h20);
            low = BUFN + 1;
        end else if (b == 8'h09 && TAB_EN) begin
            m_col = (m_col / 8 + 1) * 8;
            if (m_col >= COLS) begin
                m_col = 0;
                model_newline(low);
            end
        end else if (b >= 8'h20 && b != 8'h7F) begin
            push_wr(phys(m_row) + m_col, b);
            wen   = 1'b1;
            m_col = m_col + 1;
            if (m_col == COLS) begin
                m_col = 0;
                model_newline(low);
            end
        end
        e.col = 7'(m_col);
        e.row = 5'(m_row);
        e.top = 5'(m_top);
        e.wen = wen;
        e.low = 12'(low);
        q_cur.push_back(e);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n = n + 1;
            if (n > 5000) begin
                $display("FAIL ready_timeout got in_ready=0 for %0d cycles want 1", n);
                $fatal(1, "in_ready never returned");
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready();
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        model_byte(b);
        #1 in_valid = 1'b0;
    endtask

    // Monitor: the only process that compares and steps the counters.
    initial begin
        logic [18:0] exp;
        cur_t        c;
        bit          prev_ok, prev_ready, prev_wen, tracking;
        int          low_cnt, exp_low;
        prev_ok = 0; prev_ready = 0; prev_wen = 0; tracking = 0;
        low_cnt = 0; exp_low = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                n_checks++;
                if ({in_ready, buf_wen, buf_waddr, buf_din, top_row, cur_col, cur_row} != '0) begin
                    n_fail++;
                    $display("FAIL reset_state got rdy=%0d wen=%0d addr=%0d din=%h top=%0d col=%0d row=%0d want all 0",
                             in_ready, buf_wen, buf_waddr, buf_din, top_row, cur_col, cur_row);
                end
                prev_ok  = 0;
                tracking = 0;
            end else begin
                if (buf_wen) begin
                    n_checks++;
                    if (q_wr.size() == 0) begin
                        n_fail++;
                        $display("FAIL write_unexpected got addr=%0d din=%h want no write", buf_waddr, buf_din);
                    end else begin
                        exp = q_wr.pop_front();
                        if ({buf_waddr, buf_din} != exp) begin
                            n_fail++;
                            $display("FAIL write got addr=%0d din=%h want addr=%0d din=%h",
                                     buf_waddr, buf_din, exp[18:8], exp[7:0]);
                        end
                    end
                end
                if (prev_ok && in_ready && !prev_ready) begin
                    n_checks++;
                    if (!prev_wen) begin
                        n_fail++;
                        $display("FAIL ready_rise got prev_wen=0 want 1 (clear write just before ready)");
                    end
                end
                if (tracking) begin
                    if (!in_ready) low_cnt++;
                    else begin
                        n_checks++;
                        if (low_cnt != exp_low) begin
                            n_fail++;
                            $display("FAIL ready_low got %0d cycles want %0d", low_cnt, exp_low);
                        end
                        tracking = 0;
                    end
                end else if (q_cur.size() > 0) begin
                    c = q_cur.pop_front();
                    n_checks++;
                    if (cur_col != c.col || cur_row != c.row || top_row != c.top || buf_wen != c.wen) begin
                        n_fail++;
                        $display("FAIL cursor got col=%0d row=%0d top=%0d wen=%0d want col=%0d row=%0d top=%0d wen=%0d",
                                 cur_col, cur_row, top_row, buf_wen, c.col, c.row, c.top, c.wen);
                    end
                    exp_low = int'(c.low);
                    if (in_ready) begin
                        n_checks++;
                        if (exp_low != 0) begin
                            n_fail++;
                            $display("FAIL ready_low got 0 cycles want %0d", exp_low);
                        end
                    end else begin
                        low_cnt  = 1;
                        tracking = 1;
                    end
                end
                prev_ready = in_ready;
                prev_wen   = buf_wen;
                prev_ok    = 1;
                if (drv_done && !mon_done) begin
                    n_checks++;
                    if (q_wr.size() != 0 || q_cur.size() != 0) begin
                        n_fail++;
                        $display("FAIL drain got writes_left=%0d cursor_left=%0d want 0 0", q_wr.size(), q_cur.size());
                    end
                    mon_done = 1'b1;
                end
            end
        end
    end

    initial begin
        int unsigned v;
        logic [7:0]  b;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b1;
        for (int a = 0; a < BUFN; a++) push_wr(a, 8'h20);
        repeat (4) @(negedge clk);
        reset = 1'b0;

        // Printables, then a full line to force a wrap.
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h0D);
        for (int i = 0; i < COLS; i++) send_byte(8'h78);
        send_byte(8'h79);

        // Walk to the last row, scroll once, then wrap the offset fully.
        for (int i = 0; i < ROWS - 2; i++) send_byte(8'h0A);
        send_byte(8'h0A);
        send_byte(8'h7A);
        for (int i = 0; i < ROWS; i++) send_byte(8'h0A);

        // Control codes: CR, BS at column 0, tab at column 3, ignored codes, FF mid-line.
        send_byte(8'h0D);
        send_byte(8'h08);
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
        send_byte(8'h09);
        send_byte(8'h71);
        send_byte(8'h7F);
        send_byte(8'h00);
        send_byte(8'h08);
        send_byte(8'h0C);

        for (int i = 0; i < 600; i++) begin
            v = $urandom_range(0, 99);
            if (v < 60) begin
                v = $urandom_range(0, 222);
                b = (v < 95) ? 8'(32'h20 + v) : 8'(32'h80 + v - 95);
            end else if (v < 68) b = 8'h0A;
            else if (v < 73) b = 8'h0D;
            else if (v < 80) b = 8'h08;
            else if (v < 87) b = 8'h09;
            else if (v < 95) b = 8'($urandom_range(0, 31));
            else             b = 8'h7F;
            if (b == 8'h0C) b = 8'h0B;
            send_byte(b);
        end

        send_byte(8'h0C);
        send_byte(8'h21);
        wait_ready();
        repeat (4) @(negedge clk);
        drv_done = 1'b1;
        for (int i = 0; i < 100 && !mon_done; i++) @(negedge clk);
        if (!mon_done) begin
            $display("FAIL monitor_stall got mon_done=0 want 1");
            $fatal(1, "monitor did not drain");
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
